mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: CLK in 1 clock; RESET in 1 asynchronous active-high reset; one clock domain only.
REQ-002 SHALL take the EX/MEM bundle as inputs: I_MEM_PC in 32; I_MEM_ALU_result in 32 (effective address or result); I_MEM_WriteData in 32; I_MEM_regDst in 5; I_MEM_ControlReg in 20.
REQ-003 SHALL have data-memory ports: O_DM_req out 1; O_DM_we out 1; O_DM_addr out 32 (word-aligned); O_DM_wdata out 32; O_DM_be out 4; I_DM_ack in 1; I_DM_rdata in 32.
REQ-004 SHALL have MEM/WB outputs: O_WB_PC out 32; O_WB_result out 32; O_WB_regDst out 5; O_WB_RegWrite out 1; O_WB_valid out 1; O_MEM_stall out 1 (upstream holds EX/MEM while high).
REQ-005 SHALL use ControlReg fields: bit0 MemRead, bit1 MemWrite, bit2 RegWrite, bit3 MemToReg, bits5:4 size (00 byte, 01 half, 10 word), bit6 unsigned load; other bits ignored; all-zero means bubble.

Function
REQ-006 SHALL implement FSM IDLE/WAIT; IDLE on reset.
REQ-007 Non-memory op in IDLE: SHALL register PC, ALU_result, regDst, RegWrite into MEM/WB at next edge, O_WB_valid=1 unless bubble, no stall, 1-cycle latency.
REQ-008 Memory op (MemRead or MemWrite) in IDLE: SHALL drive O_MEM_stall=1 combinationally that cycle, register request fields, set O_DM_req=1 from next edge, enter WAIT.
REQ-009 In WAIT: O_DM_req, we, addr, wdata, be SHALL stay constant; O_MEM_stall=1 until the ack cycle; O_WB_valid=0 each edge without ack.
REQ-010 On I_DM_ack in WAIT: O_MEM_stall SHALL be 0 that cycle; at the edge, O_DM_req drops, the MEM/WB register loads, O_WB_valid=1, state returns to IDLE.
REQ-011 Load result: byte lane = addr[1:0], half lane = addr[1]; little-endian; sign-extend unless unsigned bit; O_WB_result = extended data when MemToReg else ALU_result.
REQ-012 Store: byte replicates wdata[7:0] to all lanes, be=1<<addr[1:0]; half replicates wdata[15:0], be=0011 or 1100 by addr[1]; word be=1111; stores force O_WB_RegWrite=0.
REQ-013 I_DM_ack outside WAIT SHALL be ignored; MemRead and MemWrite both set SHALL be treated as a write.
REQ-014 Best case: memory op presented cycle 0, ack in cycle 1, O_WB_valid high after edge ending cycle 1.

Reset
REQ-015 RESET SHALL asynchronously force state IDLE and every output to 0, including O_DM_req mid-WAIT; an outstanding access is abandoned.

Configuration
REQ-016 With MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no request, no stall, and one-cycle O_MEM_exc (out 1, reset 0) alongside O_WB_valid=1 and O_WB_RegWrite=0.
REQ-017 Without MEM_MISALIGN_TRAP_EN: O_MEM_exc port absent; misaligned low address bits ignored (half uses addr[1], word ignores addr[1:0]).

Structure
REQ-018 Package mips_mem_pkg SHALL hold ControlReg bit indices, size encodings, FSM state type.
REQ-019 Combinational sub-module mem_load_align SHALL perform lane select and extension.

Verification
REQ-020 LW, addr 0x104, ack 3 cycles after req -> stall 3 cycles, O_DM_addr=0x104, be=1111, WB result = rdata.
REQ-021 LB signed, addr 0x203, rdata 0x80FFFFFF -> result 0xFFFFFF80; LBU same -> 0x00000080.
REQ-022 SH, addr 0x302, data 0x0000ABCD -> wdata 0xABCDABCD, be=1100, we=1, O_WB_RegWrite=0.
REQ-023 ADD result 0x55 passes with no stall, O_WB_valid one edge later; ack pulsed in IDLE -> no effect.
REQ-024 RESET asserted in WAIT -> O_DM_req and all outputs 0 immediately, IDLE after release.
REQ-025 With macro, LW at 0x102 -> no req, O_MEM_exc=1 one cycle; without macro -> access to 0x100.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM stage: ControlReg bit positions, access sizes,
// FSM state encoding and the store byte-enable helper.
package mips_mem_pkg;

    localparam int CR_MEMREAD  = 0;
    localparam int CR_MEMWRITE = 1;
    localparam int CR_REGWRITE = 2;
    localparam int CR_MEMTOREG = 3;
    localparam int CR_SIZE_LO  = 4;
    localparam int CR_UNSIGNED = 6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: store_be = 4'b0001 << off;
            SZ_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the byte/half lane out of a little-endian word
// and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata[{offset, 3'b000} +: 8];
        h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: data = {{24{~is_unsigned & b[7]}}, b};
            SZ_HALF: data = {{16{~is_unsigned & h[15]}}, h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes non-memory ops through in one cycle, runs loads/stores as a
// held request/ack handshake. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] I_MEM_PC,
    input  logic [31:0] I_MEM_ALU_result,
    input  logic [31:0] I_MEM_WriteData,
    input  logic [4:0]  I_MEM_regDst,
    input  logic [19:0] I_MEM_ControlReg,
    output logic        O_DM_req,
    output logic        O_DM_we,
    output logic [31:0] O_DM_addr,
    output logic [31:0] O_DM_wdata,
    output logic [3:0]  O_DM_be,
    input  logic        I_DM_ack,
    input  logic [31:0] I_DM_rdata,
    output logic [31:0] O_WB_PC,
    output logic [31:0] O_WB_result,
    output logic [4:0]  O_WB_regDst,
    output logic        O_WB_RegWrite,
    output logic        O_WB_valid,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        O_MEM_exc,
`endif
    output logic        O_MEM_stall
);

    state_t      state;
    logic [31:0] p_pc, p_alu;
    logic [4:0]  p_rd;
    logic        p_rw, p_mtr, p_uns;
    logic [1:0]  p_size;
    logic [31:0] ld_data;

    logic        is_rd, is_wr, is_mem, bubble, trap;
    logic [1:0]  size;
    logic [31:0] st_wdata;
    logic        unused_cr;

    assign is_rd     = I_MEM_ControlReg[CR_MEMREAD];
    assign is_wr     = I_MEM_ControlReg[CR_MEMWRITE];
    assign is_mem    = is_rd | is_wr;
    assign bubble    = (I_MEM_ControlReg == '0);
    assign size      = I_MEM_ControlReg[CR_SIZE_LO +: 2];
    assign unused_cr = ^I_MEM_ControlReg[19:7];

`ifdef MEM_MISALIGN_TRAP_EN
    logic exc_q;
    assign O_MEM_exc = exc_q;
    assign trap = is_mem &
                  (((size == SZ_HALF) & I_MEM_ALU_result[0]) |
                   (size[1] & (I_MEM_ALU_result[1:0] != 2'b00)));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        case (size)
            SZ_BYTE: st_wdata = {4{I_MEM_WriteData[7:0]}};
            SZ_HALF: st_wdata = {2{I_MEM_WriteData[15:0]}};
            default: st_wdata = I_MEM_WriteData;
        endcase
    end

    // Gated by RESET so every output reads 0 while reset is held.
    always_comb begin
        if (RESET)
            O_MEM_stall = 1'b0;
        else if (state == ST_WAIT)
            O_MEM_stall = ~I_DM_ack;
        else
            O_MEM_stall = is_mem & ~trap;
    end

    mem_load_align u_align (
        .rdata       (I_DM_rdata),
        .offset      (p_alu[1:0]),
        .size        (p_size),
        .is_unsigned (p_uns),
        .data        (ld_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            O_DM_req      <= 1'b0;
            O_DM_we       <= 1'b0;
            O_DM_addr     <= '0;
            O_DM_wdata    <= '0;
            O_DM_be       <= '0;
            p_pc          <= '0;
            p_alu         <= '0;
            p_rd          <= '0;
            p_rw          <= 1'b0;
            p_mtr         <= 1'b0;
            p_uns         <= 1'b0;
            p_size        <= '0;
            O_WB_PC       <= '0;
            O_WB_result   <= '0;
            O_WB_regDst   <= '0;
            O_WB_RegWrite <= 1'b0;
            O_WB_valid    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            exc_q         <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            exc_q <= (state == ST_IDLE) & trap;
`endif
            if (state == ST_IDLE) begin
                if (is_mem & ~trap) begin
                    state      <= ST_WAIT;
                    O_DM_req   <= 1'b1;
                    O_DM_we    <= is_wr;
                    O_DM_addr  <= {I_MEM_ALU_result[31:2], 2'b00};
                    O_DM_wdata <= st_wdata;
                    O_DM_be    <= store_be(size, I_MEM_ALU_result[1:0]);
                    p_pc       <= I_MEM_PC;
                    p_alu      <= I_MEM_ALU_result;
                    p_rd       <= I_MEM_regDst;
                    // Read+write together counts as a store: never writes back.
                    p_rw       <= I_MEM_ControlReg[CR_REGWRITE] & ~is_wr;
                    p_mtr      <= I_MEM_ControlReg[CR_MEMTOREG] & ~is_wr;
                    p_uns      <= I_MEM_ControlReg[CR_UNSIGNED];
                    p_size     <= size;
                    O_WB_valid <= 1'b0;
                end else begin
                    O_WB_PC       <= I_MEM_PC;
                    O_WB_result   <= I_MEM_ALU_result;
                    O_WB_regDst   <= I_MEM_regDst;
                    O_WB_RegWrite <= I_MEM_ControlReg[CR_REGWRITE] & ~trap;
                    O_WB_valid    <= ~bubble;
                end
            end else if (I_DM_ack) begin
                state         <= ST_IDLE;
                O_DM_req      <= 1'b0;
                O_WB_PC       <= p_pc;
                O_WB_result   <= p_mtr ? ld_data : p_alu;
                O_WB_regDst   <= p_rd;
                O_WB_RegWrite <= p_rw;
                O_WB_valid    <= 1'b1;
            end else begin
                O_WB_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, pass-through, reset mid-access.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] I_MEM_PC, I_MEM_ALU_result, I_MEM_WriteData;
    logic [4:0]  I_MEM_regDst;
    logic [19:0] I_MEM_ControlReg;
    logic        O_DM_req, O_DM_we;
    logic [31:0] O_DM_addr, O_DM_wdata;
    logic [3:0]  O_DM_be;
    logic        I_DM_ack;
    logic [31:0] I_DM_rdata;
    logic [31:0] O_WB_PC, O_WB_result;
    logic [4:0]  O_WB_regDst;
    logic        O_WB_RegWrite, O_WB_valid, O_MEM_stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        O_MEM_exc;
`endif

    int compared = 0;
    int mismatched = 0;

    localparam logic [19:0] C_LW  = 20'h0002D;
    localparam logic [19:0] C_LH  = 20'h0001D;
    localparam logic [19:0] C_LB  = 20'h0000D;
    localparam logic [19:0] C_LBU = 20'h0004D;
    localparam logic [19:0] C_SH  = 20'h00012;
    localparam logic [19:0] C_SB  = 20'h00002;
    localparam logic [19:0] C_ADD = 20'h00004;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK(CLK), .RESET(RESET),
        .I_MEM_PC(I_MEM_PC), .I_MEM_ALU_result(I_MEM_ALU_result),
        .I_MEM_WriteData(I_MEM_WriteData), .I_MEM_regDst(I_MEM_regDst),
        .I_MEM_ControlReg(I_MEM_ControlReg),
        .O_DM_req(O_DM_req), .O_DM_we(O_DM_we), .O_DM_addr(O_DM_addr),
        .O_DM_wdata(O_DM_wdata), .O_DM_be(O_DM_be),
        .I_DM_ack(I_DM_ack), .I_DM_rdata(I_DM_rdata),
        .O_WB_PC(O_WB_PC), .O_WB_result(O_WB_result), .O_WB_regDst(O_WB_regDst),
        .O_WB_RegWrite(O_WB_RegWrite), .O_WB_valid(O_WB_valid),
`ifdef MEM_MISALIGN_TRAP_EN
        .O_MEM_exc(O_MEM_exc),
`endif
        .O_MEM_stall(O_MEM_stall)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic present(input logic [19:0] c, input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] rd);
        I_MEM_ControlReg = c;
        I_MEM_PC         = pc;
        I_MEM_ALU_result = alu;
        I_MEM_WriteData  = wd;
        I_MEM_regDst     = rd;
    endtask

    task automatic idle_inputs();
        present(20'h0, 32'h0, 32'h0, 32'h0, 5'd0);
        I_DM_ack   = 1'b0;
        I_DM_rdata = 32'h0;
    endtask

    // Runs one access already presented on the inputs; ack is raised in cycle ack_cyc
    // (cycle 0 = presentation). Returns observations; ends just after the final edge.
    task automatic run_mem(input int ack_cyc, input logic [31:0] rdata,
                           output int stalls, output logic [31:0] a, output logic [31:0] wdo,
                           output logic [3:0] be, output logic we, output logic held);
        stalls = 0; held = 1'b1; a = '0; wdo = '0; be = '0; we = 1'b0;
        for (int c = 0; c <= ack_cyc; c++) begin
            if (c == ack_cyc) begin
                I_DM_ack   = 1'b1;
                I_DM_rdata = rdata;
            end
            #1;
            if (O_MEM_stall) stalls++;
            if (c == 1) begin
                a = O_DM_addr; wdo = O_DM_wdata; be = O_DM_be; we = O_DM_we;
            end
            if (c >= 1 && (O_DM_req !== 1'b1 || O_DM_addr !== a || O_DM_wdata !== wdo ||
                           O_DM_be !== be || O_DM_we !== we || O_WB_valid !== 1'b0))
                held = 1'b0;
            @(posedge CLK);
            #1;
        end
        I_DM_ack = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        idle_inputs();
        tick();
        compared++;
        if ({O_DM_req, O_DM_we, O_DM_addr, O_DM_wdata, O_DM_be, O_WB_PC, O_WB_result,
             O_WB_regDst, O_WB_RegWrite, O_WB_valid, O_MEM_stall} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b pc=%h res=%h valid=%b stall=%b, required all 0",
                     O_DM_req, O_DM_we, O_DM_addr, O_DM_wdata, O_DM_be, O_WB_PC, O_WB_result, O_WB_valid, O_MEM_stall);
        end
        #2 RESET = 1'b0;
        tick();
    endtask

    task automatic test_lw();
        int s; logic [31:0] a, w; logic [3:0] be; logic we, held;
        present(C_LW, 32'h0000_0040, 32'h0000_0104, 32'h0, 5'd5);
        #1;
        compared++;
        if (O_MEM_stall !== 1'b1 || O_DM_req !== 1'b0) begin
            mismatched++;
            $display("FAIL lw_present: stall=%b req=%b, required stall=1 req=0", O_MEM_stall, O_DM_req);
        end
        #(-0) ;
        run_mem(3, 32'hDEAD_BEEF, s, a, w, be, we, held);
        compared++;
        if (s != 3) begin
            mismatched++; $display("FAIL lw_stall_cycles: got %0d, required 3", s);
        end
        compared++;
        if (a !== 32'h104 || be !== 4'b1111 || we !== 1'b0 || held !== 1'b1) begin
            mismatched++;
            $display("FAIL lw_request: addr=%h be=%b we=%b held=%b, required 00000104 1111 0 1", a, be, we, held);
        end
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'hDEAD_BEEF || O_WB_RegWrite !== 1'b1 ||
            O_WB_regDst !== 5'd5 || O_WB_PC !== 32'h40 || O_DM_req !== 1'b0) begin
            mismatched++;
            $display("FAIL lw_writeback: valid=%b res=%h rw=%b rd=%0d pc=%h req=%b, required 1 deadbeef 1 5 00000040 0",
                     O_WB_valid, O_WB_result, O_WB_RegWrite, O_WB_regDst, O_WB_PC, O_DM_req);
        end
        idle_inputs();
    endtask

    task automatic test_lb_lbu();
        int s; logic [31:0] a, w; logic [3:0] be; logic we, held;
        present(C_LB, 32'h44, 32'h0000_0203, 32'h0, 5'd6);
        run_mem(1, 32'h80FF_FFFF, s, a, w, be, we, held);
        compared++;
        if (s != 1 || a !== 32'h200 || O_WB_valid !== 1'b1 || O_WB_result !== 32'hFFFF_FF80) begin
            mismatched++;
            $display("FAIL lb_signed: stalls=%0d addr=%h valid=%b res=%h, required 1 00000200 1 ffffff80", s, a, O_WB_valid, O_WB_result);
        end
        present(C_LBU, 32'h48, 32'h0000_0203, 32'h0, 5'd6);
        run_mem(1, 32'h80FF_FFFF, s, a, w, be, we, held);
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'h0000_0080) begin
            mismatched++;
            $display("FAIL lbu_unsigned: valid=%b res=%h, required 1 00000080", O_WB_valid, O_WB_result);
        end
        present(C_LH, 32'h4C, 32'h0000_0102, 32'h0, 5'd7);
        run_mem(2, 32'h8001_1234, s, a, w, be, we, held);
        compared++;
        if (O_WB_result !== 32'hFFFF_8001 || s != 2 || held !== 1'b1) begin
            mismatched++;
            $display("FAIL lh_upper: res=%h stalls=%0d held=%b, required ffff8001 2 1", O_WB_result, s, held);
        end
        idle_inputs();
    endtask

    task automatic test_store();
        int s; logic [31:0] a, w; logic [3:0] be; logic we, held;
        present(C_SH | 20'h4, 32'h50, 32'h0000_0302, 32'h0000_ABCD, 5'd8);
        run_mem(1, 32'h1111_1111, s, a, w, be, we, held);
        compared++;
        if (w !== 32'hABCD_ABCD || be !== 4'b1100 || we !== 1'b1 || a !== 32'h300) begin
            mismatched++;
            $display("FAIL sh_request: wdata=%h be=%b we=%b addr=%h, required abcdabcd 1100 1 00000300", w, be, we, a);
        end
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_RegWrite !== 1'b0 || O_WB_result !== 32'h302) begin
            mismatched++;
            $display("FAIL sh_writeback: valid=%b rw=%b res=%h, required 1 0 00000302", O_WB_valid, O_WB_RegWrite, O_WB_result);
        end
        present(C_SB | 20'h1, 32'h54, 32'h0000_0101, 32'h1234_565A, 5'd9);
        run_mem(1, 32'h0, s, a, w, be, we, held);
        compared++;
        if (w !== 32'h5A5A_5A5A || be !== 4'b0010 || we !== 1'b1 || O_WB_RegWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL sb_rw_both: wdata=%h be=%b we=%b rw=%b, required 5a5a5a5a 0010 1 0", w, be, we, O_WB_RegWrite);
        end
        idle_inputs();
    endtask

    task automatic test_passthrough();
        present(C_ADD, 32'h80, 32'h55, 32'h0, 5'd3);
        #1;
        compared++;
        if (O_MEM_stall !== 1'b0) begin
            mismatched++; $display("FAIL add_stall: got %b, required 0", O_MEM_stall);
        end
        tick();
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'h55 || O_WB_RegWrite !== 1'b1 ||
            O_WB_regDst !== 5'd3 || O_WB_PC !== 32'h80 || O_DM_req !== 1'b0) begin
            mismatched++;
            $display("FAIL add_writeback: valid=%b res=%h rw=%b rd=%0d pc=%h req=%b, required 1 00000055 1 3 00000080 0",
                     O_WB_valid, O_WB_result, O_WB_RegWrite, O_WB_regDst, O_WB_PC, O_DM_req);
        end
        idle_inputs();
        I_DM_ack = 1'b1;
        tick();
        #1;
        compared++;
        if (O_DM_req !== 1'b0 || O_WB_valid !== 1'b0 || O_MEM_stall !== 1'b0) begin
            mismatched++;
            $display("FAIL ack_in_idle: req=%b valid=%b stall=%b, required 0 0 0", O_DM_req, O_WB_valid, O_MEM_stall);
        end
        I_DM_ack = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        present(C_ADD, 32'h90, 32'h11, 32'h0, 5'd1);
        tick();
        present(C_ADD, 32'h94, 32'h22, 32'h0, 5'd2);
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'h11 || O_WB_regDst !== 5'd1) begin
            mismatched++;
            $display("FAIL b2b_first: valid=%b res=%h rd=%0d, required 1 00000011 1", O_WB_valid, O_WB_result, O_WB_regDst);
        end
        tick();
        idle_inputs();
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'h22 || O_WB_PC !== 32'h94) begin
            mismatched++;
            $display("FAIL b2b_second: valid=%b res=%h pc=%h, required 1 00000022 00000094", O_WB_valid, O_WB_result, O_WB_PC);
        end
        tick();
        compared++;
        if (O_WB_valid !== 1'b0) begin
            mismatched++; $display("FAIL bubble_valid: got %b, required 0", O_WB_valid);
        end
    endtask

    task automatic test_misalign();
        int s; logic [31:0] a, w; logic [3:0] be; logic we, held;
        present(C_LW, 32'hA0, 32'h0000_0102, 32'h0, 5'd4);
`ifdef MEM_MISALIGN_TRAP_EN
        #1;
        compared++;
        if (O_MEM_stall !== 1'b0) begin
            mismatched++; $display("FAIL trap_stall: got %b, required 0", O_MEM_stall);
        end
        tick();
        idle_inputs();
        compared++;
        if (O_DM_req !== 1'b0 || O_MEM_exc !== 1'b1 || O_WB_valid !== 1'b1 || O_WB_RegWrite !== 1'b0) begin
            mismatched++;
            $display("FAIL trap_cycle: req=%b exc=%b valid=%b rw=%b, required 0 1 1 0", O_DM_req, O_MEM_exc, O_WB_valid, O_WB_RegWrite);
        end
        tick();
        compared++;
        if (O_MEM_exc !== 1'b0) begin
            mismatched++; $display("FAIL trap_one_cycle: exc=%b, required 0", O_MEM_exc);
        end
`else
        run_mem(1, 32'h0BAD_F00D, s, a, w, be, we, held);
        compared++;
        if (a !== 32'h100 || be !== 4'b1111 || O_WB_result !== 32'h0BAD_F00D || O_WB_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL lw_misaligned: addr=%h be=%b res=%h valid=%b, required 00000100 1111 0badf00d 1", a, be, O_WB_result, O_WB_valid);
        end
        idle_inputs();
`endif
    endtask

    task automatic test_reset_in_wait();
        present(C_LW, 32'hB0, 32'h0000_0208, 32'h0, 5'd10);
        tick();
        compared++;
        if (O_DM_req !== 1'b1) begin
            mismatched++; $display("FAIL wait_entry: req=%b, required 1", O_DM_req);
        end
        #2 RESET = 1'b1;
        #1;
        compared++;
        if ({O_DM_req, O_DM_we, O_DM_addr, O_DM_be, O_WB_valid, O_WB_result, O_MEM_stall} !== '0) begin
            mismatched++;
            $display("FAIL reset_in_wait: req=%b addr=%h be=%b valid=%b stall=%b, required all 0",
                     O_DM_req, O_DM_addr, O_DM_be, O_WB_valid, O_MEM_stall);
        end
        idle_inputs();
        tick();
        RESET = 1'b0;
        tick();
        present(C_ADD, 32'hC0, 32'h77, 32'h0, 5'd11);
        #1;
        compared++;
        if (O_MEM_stall !== 1'b0) begin
            mismatched++; $display("FAIL post_reset_idle: stall=%b, required 0", O_MEM_stall);
        end
        tick();
        idle_inputs();
        compared++;
        if (O_WB_valid !== 1'b1 || O_WB_result !== 32'h77) begin
            mismatched++;
            $display("FAIL post_reset_add: valid=%b res=%h, required 1 00000077", O_WB_valid, O_WB_result);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_lbu();
        test_store();
        test_passthrough();
        test_back_to_back();
        test_misalign();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
